// File: rtl/tile_map_pkg.sv
// rtl/tile_map_pkg.sv - shared timing, tile geometry, tile codes and read-pipe tags
package tile_map_pkg;

    localparam int H_VISIBLE  = 640;
    localparam int H_TOTAL    = 800;
    localparam int V_VISIBLE  = 480;
    localparam int V_TOTAL    = 525;

    localparam int TILE_SHIFT = 5;
    localparam int MAP_COLS   = 20;
    localparam int MAP_ROWS   = 15;
    localparam int MAP_DEPTH  = MAP_COLS * MAP_ROWS;

    localparam logic [3:0] EMPTY = 4'd0;
    localparam logic [3:0] PIPE  = 4'd1;
    localparam logic [3:0] DIRT  = 4'd2;
    localparam logic [3:0] ROBOT = 4'd3;

    typedef enum logic [1:0] {
        TAG_NONE   = 2'd0,
        TAG_RENDER = 2'd1,
        TAG_READ   = 2'd2
    } tag_t;

endpackage

// File: rtl/tile_index_calc.sv
// rtl/tile_index_calc.sv - (row, col) to linear tile index row*20+col
module tile_index_calc (
    input  logic [3:0] row,
    input  logic [4:0] col,
    output logic [8:0] tile_index
);

    // row*20 = row*16 + row*4
    assign tile_index = {1'b0, row, 4'b0000} + {3'b000, row, 2'b00} + {4'b0000, col};

endmodule

// File: rtl/tile_map_arbiter.sv
// rtl/tile_map_arbiter.sv - tile-map RAM arbiter: render prefetch, writer/reader round-robin, frame tick
module tile_map_arbiter
    import tile_map_pkg::*;
(
    input  logic       clock_25,
    input  logic       reset_key,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       wr_req,
    input  logic [8:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       wr_ack,
    input  logic       rd_req,
    input  logic [8:0] rd_addr,
    output logic       rd_valid,
    output logic [3:0] rd_data,
    output logic       addr_err,
    output logic [8:0] ram_addr,
    output logic       ram_we,
    output logic [3:0] ram_wdata,
    input  logic [3:0] ram_rdata,
    output logic [3:0] tile_code,
    output logic       frame_tick
);

    logic [9:0] next_y;
    logic       mid_slot, line_slot, render_slot;
    logic [3:0] fetch_row;
    logic [4:0] fetch_col;
    logic [8:0] fetch_index;
    logic       wr_elig, rd_elig, grant_wr, grant_rd, wr_bad, rd_bad;
    logic       rr_read_first;
    logic       rd_pending;
    tag_t       tag0, tag1;

    assign next_y = (pix_y == 10'(V_TOTAL - 1)) ? 10'd0 : pix_y + 10'd1;

    // Fetch three pixels ahead so the code lands exactly on the next tile boundary.
    assign mid_slot    = (pix_x[4:0] == 5'd29) && (pix_x < 10'(H_VISIBLE - 32))
                         && (pix_y < 10'(V_VISIBLE));
    assign line_slot   = (pix_x == 10'(H_TOTAL - 3)) && (next_y < 10'(V_VISIBLE));
    assign render_slot = mid_slot || line_slot;

    assign fetch_row = line_slot ? next_y[8:5] : pix_y[8:5];
    assign fetch_col = line_slot ? 5'd0 : pix_x[9:5] + 5'd1;

    tile_index_calc u_index (
        .row        (fetch_row),
        .col        (fetch_col),
        .tile_index (fetch_index)
    );

    assign wr_bad   = wr_addr >= 9'(MAP_DEPTH);
    assign rd_bad   = rd_addr >= 9'(MAP_DEPTH);
    assign wr_elig  = wr_req && !wr_ack;
    assign rd_elig  = rd_req && !rd_pending && !rd_valid;
    assign grant_wr = !render_slot && wr_elig && (!rd_elig || !rr_read_first);
    assign grant_rd = !render_slot && rd_elig && !grant_wr;

    always_ff @(posedge clock_25 or posedge reset_key) begin
        if (reset_key) begin
            wr_ack        <= 1'b0;
            rd_valid      <= 1'b0;
            rd_data       <= 4'd0;
            addr_err      <= 1'b0;
            ram_addr      <= 9'd0;
            ram_we        <= 1'b0;
            ram_wdata     <= 4'd0;
            tile_code     <= 4'd0;
            frame_tick    <= 1'b0;
            rr_read_first <= 1'b0;
            rd_pending    <= 1'b0;
            tag0          <= TAG_NONE;
            tag1          <= TAG_NONE;
        end else begin
            wr_ack     <= 1'b0;
            rd_valid   <= 1'b0;
            addr_err   <= 1'b0;
            ram_we     <= 1'b0;
            tag0       <= TAG_NONE;
            tag1       <= tag0;
            frame_tick <= (pix_x == 10'(H_TOTAL - 1)) && (pix_y == 10'(V_VISIBLE - 1));

            case (tag1)
                TAG_RENDER: tile_code <= ram_rdata;
                TAG_READ: begin
                    rd_data    <= ram_rdata;
                    rd_valid   <= 1'b1;
                    rd_pending <= 1'b0;
                end
                default: ;
            endcase

            if (render_slot) begin
                ram_addr <= fetch_index;
                tag0     <= TAG_RENDER;
            end else if (grant_wr) begin
                wr_ack <= 1'b1;
                if (wr_bad) begin
                    addr_err <= 1'b1;
                end else begin
                    ram_addr  <= wr_addr;
                    ram_we    <= 1'b1;
                    ram_wdata <= wr_data;
                end
            end else if (grant_rd) begin
                if (rd_bad) begin
                    rd_data  <= 4'd0;
                    rd_valid <= 1'b1;
                    addr_err <= 1'b1;
                end else begin
                    ram_addr   <= rd_addr;
                    tag0       <= TAG_READ;
                    rd_pending <= 1'b1;
                end
            end

            if (!render_slot && wr_elig && rd_elig) begin
                rr_read_first <= !rr_read_first;
            end
        end
    end

endmodule

// File: tb/tb_tile_map_arbiter.sv
// tb/tb_tile_map_arbiter.sv - self-checking bench for tile_map_arbiter
module tb_tile_map_arbiter;

    logic       clock_25 = 1'b0;
    logic       reset_key;
    logic [9:0] pix_x, pix_y;
    logic       wr_req, rd_req;
    logic [8:0] wr_addr, rd_addr;
    logic [3:0] wr_data;
    logic       wr_ack, rd_valid, addr_err, ram_we, frame_tick;
    logic [3:0] rd_data, ram_wdata, ram_rdata, tile_code;
    logic [8:0] ram_addr;

    always #20 clock_25 = ~clock_25;

    tile_map_arbiter dut (
        .clock_25  (clock_25),
        .reset_key (reset_key),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .addr_err  (addr_err),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .tile_code (tile_code),
        .frame_tick(frame_tick)
    );

    logic [3:0] ram [0:511];
    logic       ram_init;

    always_ff @(posedge clock_25) begin
        if (ram_init) begin
            for (int i = 0; i < 512; i++) ram[i] <= 4'(i % 16);
        end else if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
        end
        ram_rdata <= ram[ram_addr];
    end

    typedef struct {
        bit is_wr;
        int addr;
        int data;
        bit exp_err;
        int exp_rd;
    } txn_t;

    txn_t       tbl [11];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [3:0] gold [0:299];
    bit         e_ack [4], e_we [4], e_err [4], e_rv [4], e_tv [4];
    int         e_addr [4], e_wd [4], e_rd [4], e_tile [4];
    int         cur_rd, cur_tile, w_free, r_free;
    bit         prio_read, rst_edge;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            e_ack[i] = 0; e_we[i] = 0; e_err[i] = 0; e_rv[i] = 0; e_tv[i] = 0;
        end
        cur_rd = 0; cur_tile = 0; w_free = 0; r_free = 0; prio_read = 0;
    endtask

    // Outcome of one cycle's inputs, scheduled as future output events.
    task automatic model_cycle();
        int x, y, yn, idx, s1, s3;
        bit slot, we, re, gw, gr;
        x = int'(pix_x); y = int'(pix_y);
        s1 = (cyc + 1) % 4; s3 = (cyc + 3) % 4;
        yn = (y == 524) ? 0 : y + 1;
        slot = 0; idx = 0;
        if (x % 32 == 29 && x / 32 <= 18 && y < 480) begin slot = 1; idx = (y / 32) * 20 + x / 32 + 1; end
        if (x == 797 && yn < 480) begin slot = 1; idx = (yn / 32) * 20; end
        if (slot) begin
            e_tv[s3] = 1; e_tile[s3] = int'(gold[idx]);
        end else begin
            we = wr_req && cyc >= w_free;
            re = rd_req && cyc >= r_free;
            if (we && re) begin gw = !prio_read; prio_read = !prio_read; end
            else gw = we;
            gr = re && !gw;
            if (gw) begin
                e_ack[s1] = 1; w_free = cyc + 2;
                if (int'(wr_addr) < 300) begin
                    e_we[s1] = 1; e_addr[s1] = int'(wr_addr); e_wd[s1] = int'(wr_data);
                    gold[wr_addr] = wr_data;
                end else e_err[s1] = 1;
            end
            if (gr) begin
                if (int'(rd_addr) < 300) begin
                    e_rv[s3] = 1; e_rd[s3] = int'(gold[rd_addr]); r_free = cyc + 4;
                end else begin
                    e_rv[s1] = 1; e_rd[s1] = 0; e_err[s1] = 1; r_free = cyc + 2;
                end
            end
        end
    endtask

    task automatic cycle_end();
        int s;
        if (reset_key) clear_model(); else model_cycle();
        rst_edge = reset_key;
        @(posedge clock_25);
        @(negedge clock_25);
        cyc++;
        if (pix_x == 10'd799) begin
            pix_x = 10'd0;
            pix_y = (pix_y == 10'd524) ? 10'd0 : pix_y + 10'd1;
        end else pix_x = pix_x + 10'd1;
        s = cyc % 4;
        if (e_rv[s]) cur_rd = e_rd[s];
        if (e_tv[s]) cur_tile = e_tile[s];
        check("wr_ack", int'(wr_ack), int'(e_ack[s]));
        check("ram_we", int'(ram_we), int'(e_we[s]));
        if (e_we[s]) begin
            check("ram_addr", int'(ram_addr), e_addr[s]);
            check("ram_wdata", int'(ram_wdata), e_wd[s]);
        end
        check("addr_err", int'(addr_err), int'(e_err[s]));
        check("rd_valid", int'(rd_valid), int'(e_rv[s]));
        check("rd_data", int'(rd_data), cur_rd);
        check("tile_code", int'(tile_code), cur_tile);
        check("frame_tick", int'(frame_tick), int'(!rst_edge && pix_x == 10'd0 && pix_y == 10'd480));
        e_ack[s] = 0; e_we[s] = 0; e_err[s] = 0; e_rv[s] = 0; e_tv[s] = 0;
    endtask

    task automatic run_to(input int x, input int y);
        int n;
        n = 0;
        while (!(int'(pix_x) == x && int'(pix_y) == y) && n < 2000) begin
            cycle_end();
            n++;
        end
        check("run_to_reached", int'(int'(pix_x) == x && int'(pix_y) == y), 1);
    endtask

    task automatic do_txn(input txn_t t, input int k);
        int  waited;
        bit  done;
        if (t.is_wr) begin wr_req = 1; wr_addr = 9'(t.addr); wr_data = 4'(t.data); end
        else begin rd_req = 1; rd_addr = 9'(t.addr); end
        done = 0; waited = 0;
        while (!done && waited < 40) begin
            cycle_end();
            waited++;
            if (t.is_wr && wr_ack) begin
                done = 1; wr_req = 0;
                check($sformatf("txn%0d_err", k), int'(addr_err), int'(t.exp_err));
            end
            if (!t.is_wr && rd_valid) begin
                done = 1; rd_req = 0;
                check($sformatf("txn%0d_err", k), int'(addr_err), int'(t.exp_err));
                check($sformatf("txn%0d_rdata", k), int'(rd_data), t.exp_rd);
            end
        end
        check($sformatf("txn%0d_done", k), int'(done), 1);
        wr_req = 0; rd_req = 0;
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, wa, rv, rdv, cnt, tx, ty, bad;
        reset_key = 1; ram_init = 1; pix_x = 0; pix_y = 0;
        wr_req = 0; rd_req = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
        for (int i = 0; i < 300; i++) gold[i] = 4'(i % 16);
        clear_model();
        rst_edge = 1;
        tbl[0]  = '{1'b1,  21, 10, 1'b0,  0};
        tbl[1]  = '{1'b0,  21,  0, 1'b0, 10};
        tbl[2]  = '{1'b0, 300,  0, 1'b1,  0};
        tbl[3]  = '{1'b1, 511,  3, 1'b1,  0};
        tbl[4]  = '{1'b0,   5,  0, 1'b0,  7};
        tbl[5]  = '{1'b0, 299,  0, 1'b0, 11};
        tbl[6]  = '{1'b1,   0, 15, 1'b0,  0};
        tbl[7]  = '{1'b0,   0,  0, 1'b0, 15};
        tbl[8]  = '{1'b1, 298,  2, 1'b0,  0};
        tbl[9]  = '{1'b0, 298,  0, 1'b0,  2};
        tbl[10] = '{1'b0,  20,  0, 1'b0,  4};

        @(negedge clock_25);
        cycle_end();
        cycle_end();
        ram_init = 0;
        check("reset_state", int'({wr_ack, rd_valid, rd_data, addr_err, ram_addr, ram_we,
                                   ram_wdata, tile_code, frame_tick}), 0);
        reset_key = 0;

        // First visible line: transitions exactly on 32-pixel boundaries.
        pix_x = 10'd790; pix_y = 10'd524;
        run_to(0, 0);   check("tile_x0_y0", int'(tile_code), 0);
        run_to(31, 0);  check("tile_x31_y0", int'(tile_code), 0);
        run_to(32, 0);  check("tile_x32_y0", int'(tile_code), 1);
        run_to(639, 0); check("tile_x639_y0", int'(tile_code), 3);

        // Simultaneous write and read of the same index just after reset.
        wr_req = 1; wr_addr = 9'd5; wr_data = 4'd7;
        rd_req = 1; rd_addr = 9'd5;
        t0 = cyc; wa = -1; rv = -1; rdv = -1;
        for (int n = 0; n < 20 && (wa < 0 || rv < 0); n++) begin
            cycle_end();
            if (wr_ack && wa < 0) begin wa = cyc; wr_req = 0; end
            if (rd_valid && rv < 0) begin rv = cyc; rdv = int'(rd_data); rd_req = 0; end
        end
        wr_req = 0; rd_req = 0;
        check("wr_then_rd_ack_latency", wa - t0, 1);
        check("wr_then_rd_valid_latency", rv - t0, 4);
        check("wr_then_rd_data", rdv, 7);

        for (int k = 0; k < 11; k++) do_txn(tbl[k], k);

        pix_x = 10'd790; pix_y = 10'd39;
        run_to(31, 40); check("tile_x31_y40", int'(tile_code), 4);
        run_to(32, 40); check("tile_x32_y40", int'(tile_code), 10);
        run_to(63, 40); check("tile_x63_y40", int'(tile_code), 10);
        run_to(64, 40); check("tile_x64_y40", int'(tile_code), 6);

        pix_x = 10'd790; pix_y = 10'd478;
        run_to(639, 479); check("tile_x639_y479", int'(tile_code), 11);

        // Random contention between writer and reader across render slots.
        pix_x = 10'd0; pix_y = 10'd200;
        for (int n = 0; n < 3000; n++) begin
            cycle_end();
            if (wr_ack) wr_req = 0;
            if (rd_valid) rd_req = 0;
            if (!wr_req && $urandom_range(0, 2) == 0) begin
                wr_req = 1;
                wr_addr = ($urandom_range(0, 15) == 0) ? 9'($urandom_range(300, 511))
                                                       : 9'($urandom_range(0, 299));
                wr_data = 4'($urandom_range(0, 15));
            end
            if (!rd_req && $urandom_range(0, 2) == 0) begin
                rd_req = 1;
                rd_addr = ($urandom_range(0, 15) == 0) ? 9'($urandom_range(300, 511))
                                                       : 9'($urandom_range(0, 299));
            end
        end
        wr_req = 0; rd_req = 0;
        for (int n = 0; n < 6; n++) cycle_end();

        // Reset while a read is in flight.
        rd_req = 1; rd_addr = 9'd10;
        cycle_end();
        rd_req = 0; reset_key = 1;
        cycle_end();
        cycle_end();
        check("reset_mid_outputs", int'({wr_ack, rd_valid, rd_data, addr_err, ram_addr, ram_we,
                                         ram_wdata, tile_code, frame_tick}), 0);
        reset_key = 0;
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            cycle_end();
            if (rd_valid) cnt++;
        end
        check("no_rd_valid_after_reset", cnt, 0);

        pix_x = 10'd700; pix_y = 10'd479;
        cnt = 0; tx = -1; ty = -1;
        for (int n = 0; n < 300; n++) begin
            cycle_end();
            if (frame_tick) begin cnt++; tx = int'(pix_x); ty = int'(pix_y); end
        end
        check("frame_tick_count", cnt, 1);
        check("frame_tick_x", tx, 0);
        check("frame_tick_y", ty, 480);

        bad = 0;
        for (int i = 0; i < 300; i++) if (ram[i] != gold[i]) bad++;
        check("ram_contents", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
